// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - load/store initiator for the 128-byte data memory
// Loads are single big-endian word reads; stores are sequenced one byte per clock.
module dm_access_unit #(
    parameter int DATA_MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, stateNext;
    logic [31:0] addrReg, wdataReg, rdataReg;
    logic [1:0]  sizeReg;
    logic        unsReg, errReg;
    logic [1:0]  byteCnt;

    logic        accept;
    logic [2:0]  reqLen;
    logic [32:0] lastAddr;
    logic        reqErr;
    logic [1:0]  lastK, shiftAmt;
    logic [31:0] shiftedData;
    logic [31:0] loadValue;

    assign accept = req_valid && req_ready;

    always_comb begin
        case (req_size)
            2'b00:   reqLen = 3'd1;
            2'b01:   reqLen = 3'd2;
            default: reqLen = 3'd4;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign lastAddr = {1'b0, req_addr} + {30'b0, reqLen} - 33'd1;
    assign reqErr   = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (lastAddr > 33'(DATA_MEM_SIZE - 1));

    // Byte k of an N-byte store is the k-th most significant of the low N bytes
    assign lastK       = (sizeReg == 2'b10) ? 2'd3 : (sizeReg == 2'b01) ? 2'd1 : 2'd0;
    assign shiftAmt    = lastK - byteCnt;
    assign shiftedData = wdataReg >> {shiftAmt, 3'b000};

    always_comb begin
        case (sizeReg)
            2'b00:   loadValue = {{24{~unsReg & MemReadData[31]}}, MemReadData[31:24]};
            2'b01:   loadValue = {{16{~unsReg & MemReadData[31]}}, MemReadData[31:16]};
            default: loadValue = MemReadData;
        endcase
    end

    always_comb begin
        stateNext    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = 32'd0;
        resp_err     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddr      = 32'd0;
        MemWriteData = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !rst) begin
                    if (reqErr)         stateNext = RESP;
                    else if (req_write) stateNext = WRITE;
                    else                stateNext = READ;
                end
            end
            READ: begin
                MemRead   = 1'b1;
                MemAddr   = addrReg;
                stateNext = RESP;
            end
            WRITE: begin
                MemWrite     = 1'b1;
                MemAddr      = addrReg + {30'b0, byteCnt};
                MemWriteData = {24'b0, shiftedData[7:0]};
                if (byteCnt == lastK) stateNext = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdataReg;
                resp_err   = errReg;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Reset forces idle outputs immediately so no further byte is committed
        if (rst) begin
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            resp_rdata   = 32'd0;
            resp_err     = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            MemAddr      = 32'd0;
            MemWriteData = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addrReg  <= 32'd0;
            wdataReg <= 32'd0;
            rdataReg <= 32'd0;
            sizeReg  <= 2'd0;
            unsReg   <= 1'b0;
            errReg   <= 1'b0;
            byteCnt  <= 2'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                addrReg  <= req_addr;
                wdataReg <= req_wdata;
                sizeReg  <= req_size;
                unsReg   <= req_unsigned;
                errReg   <= reqErr;
                rdataReg <= 32'd0;
                byteCnt  <= 2'd0;
            end
            if (state == READ)  rdataReg <= loadValue;
            if (state == WRITE) byteCnt  <= byteCnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - randomized bench for dm_access_unit against a byte-array memory model
// The DUT drives a bench-owned memory; expectations come from a separate reference array.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem     [128];
    logic [7:0]  refMem  [128];
    logic [7:0]  initVal [128];
    logic        memInit = 1'b1;
    logic [31:0] rdIdx;

    dm_access_unit #(.DATA_MEM_SIZE(128)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 128; i++) mem[i] <= initVal[i];
        end else if (MemWrite && MemAddr < 32'd128) begin
            mem[MemAddr[6:0]] <= MemWriteData[7:0];
        end
    end

    always_comb begin
        rdIdx       = 32'd0;
        MemReadData = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rdIdx = MemAddr + 32'(i);
            MemReadData[31-8*i -: 8] = (rdIdx < 32'd128) ? mem[rdIdx[6:0]] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request starting just after a rising edge and follows it to completion.
    task automatic doReq(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep);
        int          n, lat, waited;
        bit          err;
        longint      last;
        logic [31:0] expR;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'(a) + longint'(n) - 1;
        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (last > 127);
        expR = 32'd0;
        if (!err && !wr) begin
            for (int i = 0; i < n; i++) expR = (expR << 8) | {24'd0, refMem[int'(a) + i]};
            if (n < 4 && !uns && expR[8*n-1]) expR = expR | (32'hFFFFFFFF << (8*n));
        end
        lat = err ? 1 : (wr ? n + 1 : 2);

        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
            if (c < lat) begin
                chk("early_resp", {31'd0, resp_valid}, 32'd0);
                if (!wr) begin
                    chk("rd_strobe", {30'd0, MemRead, MemWrite}, 32'd2);
                    chk("rd_addr", MemAddr, a);
                end else begin
                    chk("wr_strobe", {30'd0, MemRead, MemWrite}, 32'd1);
                    chk("wr_addr", MemAddr, a + 32'(c - 1));
                    chk("wr_data", MemWriteData, {24'd0, wd[8*(n-c) +: 8]});
                end
            end else begin
                chk("resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("resp_err", {31'd0, resp_err}, {31'd0, err});
                chk("resp_rdata", resp_rdata, expR);
                chk("resp_strobe", {30'd0, MemRead, MemWrite}, 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("resp_clear", {31'd0, resp_valid}, 32'd0);
        if (wr && !err)
            for (int k = 0; k < n; k++) refMem[int'(a) + k] = wd[8*(n-1-k) +: 8];
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 128; i++) begin
            initVal[i] = 8'($urandom);
            refMem[i]  = initVal[i];
        end
        // request held during reset must never be accepted
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1 memInit = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_strobe", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWriteData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_wr", {31'd0, MemWrite}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_accept_in_rst", {30'd0, MemWrite, resp_valid}, 32'd0);
        @(posedge clk); #1;

        doReq(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        doReq(0, 2'd2, 0, 32'h10, 32'h0, 0);
        doReq(1, 2'd1, 0, 32'h22, 32'h0000F00D, 0);
        doReq(0, 2'd1, 0, 32'h22, 32'h0, 0);
        doReq(0, 2'd1, 1, 32'h22, 32'h0, 0);
        doReq(0, 2'd0, 0, 32'h23, 32'h0, 0);
        doReq(1, 2'd0, 0, 32'h7F, 32'h00000080, 0);
        doReq(0, 2'd0, 0, 32'h7F, 32'h0, 0);
        doReq(0, 2'd0, 1, 32'h7F, 32'h0, 0);
        doReq(0, 2'd2, 0, 32'h02, 32'h0, 0);
        doReq(1, 2'd1, 0, 32'h05, 32'h1234, 0);
        doReq(0, 2'd2, 0, 32'h7E, 32'h0, 0);
        doReq(0, 2'd2, 0, 32'h80, 32'h0, 0);
        doReq(0, 2'd3, 0, 32'h00, 32'h0, 0);
        doReq(1, 2'd3, 0, 32'h00, 32'h55, 0);
        doReq(0, 2'd0, 0, 32'hFFFFFFFF, 32'h0, 0);
        doReq(1, 2'd2, 0, 32'hFFFFFFFC, 32'h01020304, 0);

        // reset after two of four store bytes
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_wr", {30'd0, MemRead, MemWrite}, 32'd1);
            chk("abort_addr", MemAddr, 32'h40 + 32'(c));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_gated", {31'd0, MemWrite}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", {31'd0, req_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_resp", {30'd0, resp_valid, MemWrite}, 32'd0);
            @(negedge clk);
        end
        refMem[8'h40] = 8'h11;
        refMem[8'h41] = 8'h22;
        for (int i = 'h40; i < 'h44; i++) chk("abort_mem", {24'd0, mem[i]}, {24'd0, refMem[i]});
        @(posedge clk); #1;

        // req_valid held high across alternating loads and stores
        for (int i = 0; i < 8; i++) doReq(bit'(i % 2), 2'd2, 0, 32'h30, $urandom, 1);
        req_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 135));
            doReq(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a, $urandom,
                  bit'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;

        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== refMem[i]) diffs++;
        chk("mem_final", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

CPU-side load/store initiator for the 128-byte data memory. Accepts one load or store request at a time from the pipeline and drives the data memory port. Loads are one-cycle big-endian word reads, with byte/half extraction and sign or zero extension. Stores are sequenced one byte per clock, because the data memory port commits one byte (MemWriteData[7:0]) per write cycle. Misaligned, out-of-range and illegal-size requests are rejected without touching memory.

## Interface
- DATA_MEM_SIZE, 128: data memory size in bytes; legal addresses are 0..DATA_MEM_SIZE-1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE with rst low.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address A.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected; valid with resp_valid.
- MemAddr  out  32  data memory byte address.
- MemWriteData  out  32  store byte in [7:0]; [31:8] always 0.
- MemWrite  out  1  byte write strobe.
- MemRead  out  1  read enable.
- MemReadData  in  32  combinational read: {M[MemAddr], M[MemAddr+1], M[MemAddr+2], M[MemAddr+3]}.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: the request is accepted when req_valid && req_ready. All request fields are latched on acceptance. Inputs are ignored outside IDLE.
- Error check at acceptance, with N = 1/2/4 bytes for size 00/01/10. resp_err is set if any of:
  - size is 11;
  - half with A[0]=1;
  - word with A[1:0]≠0;
  - A+N-1 > DATA_MEM_SIZE-1, computed at 33 bits so A near 2^32 cannot wrap.
- On error: IDLE→RESP directly. No MemRead or MemWrite is asserted.
- Load: IDLE→READ. In READ: MemRead=1, MemAddr=A, and the word W=MemReadData is captured at the clock edge. Then READ→RESP.
  - Byte: W[31:24], extended to 32 bits.
  - Half: W[31:16], extended to 32 bits.
  - Word: W unchanged; req_unsigned is ignored.
  - Bytes beyond A+N-1 are don't-care.
- Store: IDLE→WRITE with byte counter k=0. In WRITE: MemWrite=1, MemAddr=A+k, MemWriteData={24'b0, byte k}.
  - Byte order is big-endian: byte 0 is the most significant of the N stored bytes.
  - Word: k=0..3 takes wdata[31:24], [23:16], [15:8], [7:0].
  - Half: k=0..1 takes wdata[15:8], [7:0].
  - Byte: k=0 takes wdata[7:0].
  - When k=N-1, go WRITE→RESP.
- RESP: resp_valid=1 for one cycle, then RESP→IDLE.
- Outside READ/WRITE, MemRead, MemWrite, MemAddr and MemWriteData are all 0.

## Timing
- Reset values: state IDLE; req_ready, resp_valid, resp_err, MemRead and MemWrite all 0; resp_rdata, MemAddr and MemWriteData all 0.
- req_ready goes to 1 in the first cycle after rst deasserts.
- With acceptance at cycle T:
  - Load: MemRead during T+1; resp_valid at T+2.
  - Store of N bytes: MemWrite during T+1..T+N; resp_valid at T+N+1.
  - Error: resp_valid with resp_err=1 at T+1.
- req_ready is low from T+1 through the resp_valid cycle inclusive, and high again the cycle after. Back-to-back throughput is therefore one request per latency+1 cycles.
- resp_rdata and resp_err hold their values only while resp_valid=1. They are 0 otherwise.
- Reset mid-operation: on the next edge, all outputs take their reset values and the state returns to IDLE.
  - Remaining store bytes are not written; bytes already written stay in memory.
  - No resp_valid is produced for the aborted request.
- req_valid asserted during rst is not accepted.

## Test plan
- sw A=0x10, wdata=0xDEADBEEF → MemWrite on 4 consecutive cycles at 0x10..0x13 with data 0xDE, 0xAD, 0xBE, 0xEF; resp_valid 5 cycles after accept; a following lw 0x10 → resp_rdata=0xDEADBEEF at accept+2.
- sh 0x22, wdata=0x0000F00D; then lh 0x22 → 0xFFFFF00D; lhu 0x22 → 0x0000F00D; lb 0x23 → 0x0000000D.
- sb 0x7F, wdata=0x00000080; then lb 0x7F → 0xFFFFFF80; lbu 0x7F → 0x00000080 (last legal byte, no range error).
- lw 0x02, sh 0x05, lw 0x7E, lw 0x80, size 11 → each gives resp_err=1 at accept+1, resp_rdata=0, and MemRead/MemWrite never asserted.
- rst pulsed after 2 of 4 sw byte writes (A=0x40, wdata=0x11223344) → M[0x40]=0x11 and M[0x41]=0x22; M[0x42..0x43] unchanged; no resp_valid; req_ready=1 the cycle after rst drops.
- Hold req_valid high continuously with alternating load and store requests → exactly one accept per IDLE cycle, no overlapping responses, and each latency as specified above.
